line_memory_responder: RTL and testbench

LINE_MEMORY_RESPONDER -- requirements
Module: line_memory_responder

---
 rtl/line_memory_responder.sv | 169 ++++++++++++++++
 tb/tb_line_memory_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Behavioural line-granular backing memory serving an instruction-cache read port
// and a data-cache read/write port, one line transaction at a time.
module line_memory_responder #(
    parameter int unsigned BYTE_OFF_BITS  = 5,
    parameter int unsigned MEM_WORDS      = 16384,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned ACCESS_LATENCY = 4,
    localparam int unsigned NB_WORDS      = (2 ** BYTE_OFF_BITS) / 4,
    localparam int unsigned LINE_SIZE     = 32 * NB_WORDS
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 instr_read_en_i,
    input  logic [31:0]          instr_addr_i,
    output logic                 instr_read_valid_o,
    output logic [LINE_SIZE-1:0] instr_read_data_o,
    input  logic                 data_read_en_i,
    input  logic                 data_write_en_i,
    input  logic [31:0]          data_addr_i,
    input  logic [LINE_SIZE-1:0] data_write_data_i,
    output logic                 data_read_valid_o,
    output logic [LINE_SIZE-1:0] data_read_data_o,
    output logic                 data_write_valid_o,
    output logic                 busy_o
);

    localparam int unsigned WCNT_W     = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam int unsigned LCNT_W     = $clog2(ACCESS_LATENCY + 2);
    localparam int unsigned IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] LINE_MASK  = ~((32'd1 << BYTE_OFF_BITS) - 32'd1);
    localparam logic [32:0] LINE_BYTES = 33'd1 << BYTE_OFF_BITS;
    localparam logic [32:0] MEM_BYTES  = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {IDLE, WAIT, BURST, RESP, GAP} state_t;
    typedef enum logic [1:0] {OP_IRD, OP_DRD, OP_DWR} op_t;

    state_t               state;
    op_t                  op;
    op_t                  grant_op;
    logic                 grant;
    logic                 favour_data;
    logic [LCNT_W-1:0]    lat_cnt;
    logic [WCNT_W-1:0]    wcnt;

    logic [31:0]          grant_addr;
    logic [31:0]          grant_line_addr;
    logic [32:0]          offset_c;
    logic                 in_range_c;
    logic                 in_range;
    logic [IDX_W-1:0]     base_idx;
    logic [IDX_W-1:0]     mem_idx;
    logic [31:0]          rd_word;
    logic [31:0]          wr_word;
    logic [LINE_SIZE-1:0] wr_line;
    logic [LINE_SIZE-1:0] line_buf;
    logic [LINE_SIZE-1:0] fill_line;
    logic [31:0]          mem [MEM_WORDS];

    // Writes always win; reads alternate, favouring whichever port was not served last.
    always_comb begin
        grant    = 1'b0;
        grant_op = OP_DRD;
        if (data_write_en_i) begin
            grant    = 1'b1;
            grant_op = OP_DWR;
        end else if (data_read_en_i && (!instr_read_en_i || favour_data)) begin
            grant    = 1'b1;
            grant_op = OP_DRD;
        end else if (instr_read_en_i) begin
            grant    = 1'b1;
            grant_op = OP_IRD;
        end
    end

    assign grant_addr      = (grant_op == OP_IRD) ? instr_addr_i : data_addr_i;
    assign grant_line_addr = grant_addr & LINE_MASK;
    assign offset_c        = {1'b0, grant_line_addr} - {1'b0, BASE_ADDR};
    assign in_range_c      = !offset_c[32] && ((offset_c + LINE_BYTES) <= MEM_BYTES);

    assign mem_idx = base_idx + IDX_W'(wcnt);
    assign rd_word = in_range ? mem[mem_idx] : 32'h0;
    assign wr_word = wr_line[wcnt*32 +: 32];
    assign busy_o  = (state != IDLE);

    // The final word bypasses the buffer so the full line is available at the RESP edge.
    always_comb begin
        fill_line                  = line_buf;
        fill_line[wcnt*32 +: 32]   = rd_word;
    end

    always_ff @(posedge clk_i) begin
        if (state == IDLE && grant) begin
            wr_line  <= data_write_data_i;
            base_idx <= offset_c[IDX_W+1:2];
            in_range <= in_range_c;
        end
        if (state == BURST) begin
            line_buf <= fill_line;
            if (op == OP_DWR && in_range) begin
                mem[mem_idx] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= IDLE;
            op                 <= OP_DRD;
            favour_data        <= 1'b1;
            lat_cnt            <= '0;
            wcnt               <= '0;
            instr_read_valid_o <= 1'b0;
            data_read_valid_o  <= 1'b0;
            data_write_valid_o <= 1'b0;
            instr_read_data_o  <= '0;
            data_read_data_o   <= '0;
        end else begin
            instr_read_valid_o <= 1'b0;
            data_read_valid_o  <= 1'b0;
            data_write_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        op      <= grant_op;
                        lat_cnt <= '0;
                        wcnt    <= '0;
                        if (grant_op == OP_DRD) begin
                            favour_data <= 1'b0;
                        end else if (grant_op == OP_IRD) begin
                            favour_data <= 1'b1;
                        end
                        state <= (ACCESS_LATENCY == 0) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LCNT_W'(ACCESS_LATENCY - 1)) begin
                        lat_cnt <= '0;
                        state   <= BURST;
                    end else begin
                        lat_cnt <= lat_cnt + LCNT_W'(1);
                    end
                end
                BURST: begin
                    if (wcnt == WCNT_W'(NB_WORDS - 1)) begin
                        wcnt  <= '0;
                        state <= RESP;
                        case (op)
                            OP_IRD: begin
                                instr_read_valid_o <= 1'b1;
                                instr_read_data_o  <= fill_line;
                            end
                            OP_DRD: begin
                                data_read_valid_o <= 1'b1;
                                data_read_data_o  <= fill_line;
                            end
                            default: data_write_valid_o <= 1'b1;
                        endcase
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                RESP:    state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: default build plus a zero-latency build.
module tb_line_memory_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn;
    logic         i_en, i_vld, d_rd, d_wr, d_rvld, d_wvld, busy;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata, i_data, d_rdata;
    logic         z_i_en, z_i_vld, z_d_rd, z_d_wr, z_d_rvld, z_d_wvld, z_busy;
    logic [31:0]  z_i_addr, z_d_addr;
    logic [255:0] z_d_wdata, z_i_data, z_d_rdata;

    line_memory_responder dut (
        .clk_i(clk), .rstn_i(rstn),
        .instr_read_en_i(i_en), .instr_addr_i(i_addr),
        .instr_read_valid_o(i_vld), .instr_read_data_o(i_data),
        .data_read_en_i(d_rd), .data_write_en_i(d_wr), .data_addr_i(d_addr),
        .data_write_data_i(d_wdata), .data_read_valid_o(d_rvld),
        .data_read_data_o(d_rdata), .data_write_valid_o(d_wvld), .busy_o(busy)
    );

    line_memory_responder #(.ACCESS_LATENCY(0)) dut_z (
        .clk_i(clk), .rstn_i(rstn),
        .instr_read_en_i(z_i_en), .instr_addr_i(z_i_addr),
        .instr_read_valid_o(z_i_vld), .instr_read_data_o(z_i_data),
        .data_read_en_i(z_d_rd), .data_write_en_i(z_d_wr), .data_addr_i(z_d_addr),
        .data_write_data_i(z_d_wdata), .data_read_valid_o(z_d_rvld),
        .data_read_data_o(z_d_rdata), .data_write_valid_o(z_d_wvld), .busy_o(z_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // kind: 0 instr read, 1 data read, 2 data write. Entered and left in an IDLE cycle, #1 after an edge.
    task automatic run_txn(input bit sel_z, input int kind, input logic [31:0] addr,
                           input logic [255:0] wd, output int lat, output logic [255:0] rdata);
        logic v;
        if (!sel_z) begin
            if (kind == 0) begin i_en = 1'b1; i_addr = addr; end
            else if (kind == 1) begin d_rd = 1'b1; d_addr = addr; end
            else begin d_wr = 1'b1; d_addr = addr; d_wdata = wd; end
        end else begin
            if (kind == 0) begin z_i_en = 1'b1; z_i_addr = addr; end
            else if (kind == 1) begin z_d_rd = 1'b1; z_d_addr = addr; end
            else begin z_d_wr = 1'b1; z_d_addr = addr; z_d_wdata = wd; end
        end
        @(posedge clk);
        lat = -1;
        rdata = '0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (!sel_z) v = (kind == 0) ? i_vld : (kind == 1) ? d_rvld : d_wvld;
            else        v = (kind == 0) ? z_i_vld : (kind == 1) ? z_d_rvld : z_d_wvld;
            if (v) begin
                lat = k;
                if (!sel_z) rdata = (kind == 0) ? i_data : d_rdata;
                else        rdata = (kind == 0) ? z_i_data : z_d_rdata;
                break;
            end
        end
        i_en = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        z_i_en = 1'b0; z_d_rd = 1'b0; z_d_wr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int           lat, wlat, rlat, dn, in_n, d_mark, i_mark, seen;
    int           dv[2], iv[2];
    logic [255:0] rd, d_cap, i_cap;
    logic [255:0] line_a, line_b, line_c, line_d, line_e;

    initial begin
        line_a = mk_line(32'h1000_0000);
        line_b = mk_line(32'h2000_0010);
        line_c = mk_line(32'hdead_0000);
        line_d = mk_line(32'h3300_0100);
        line_e = mk_line(32'h4400_0200);
        rstn = 1'b0;
        i_en = 0; d_rd = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        z_i_en = 0; z_d_rd = 0; z_d_wr = 0; z_i_addr = '0; z_d_addr = '0; z_d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_valids", 256'({i_vld, d_rvld, d_wvld}), 256'd0);
        check("rst_idata", i_data, '0);
        check("rst_ddata", d_rdata, '0);
        check("rst_z_busy", 256'(z_busy), 256'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Write a line then read it back through the instruction port at an unaligned address
        run_txn(0, 2, 32'h100, line_a, lat, rd);
        check("wr_lat", 256'(lat), 256'd12);
        run_txn(0, 0, 32'h104, '0, lat, rd);
        check("ird_lat", 256'(lat), 256'd12);
        check("ird_data", rd, line_a);

        // Simultaneous read and write to the same line: write first
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h200; d_wdata = line_b;
        wlat = -1; rlat = -1;
        @(posedge clk);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (d_wvld && wlat < 0) begin wlat = k; d_wr = 1'b0; end
            if (d_rvld) begin rlat = k; d_rd = 1'b0; break; end
        end
        d_rd = 1'b0; d_wr = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rw_wlat", 256'(wlat), 256'd12);
        check("rw_rlat", 256'(rlat), 256'd27);
        check("rw_rdata", d_rdata, line_b);
        check("idata_held", i_data, line_a);

        // Fresh reset so the data port is favoured; both ports held, alternating service
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        i_addr = 32'h100; d_addr = 32'h200; i_en = 1'b1; d_rd = 1'b1;
        dn = 0; in_n = 0; d_mark = -10; i_mark = -10;
        dv[0] = 0; dv[1] = 0; iv[0] = 0; iv[1] = 0;
        d_cap = '0; i_cap = '0;
        @(posedge clk);
        for (int k = 1; k <= 58; k++) begin
            @(posedge clk);
            #1;
            if (k == d_mark + 1) d_rd = 1'b0;
            if (k == d_mark + 2) d_rd = 1'b1;
            if (k == i_mark + 1) i_en = 1'b0;
            if (k == i_mark + 2) i_en = 1'b1;
            if (d_rvld) begin
                if (dn < 2) dv[dn] = k;
                if (dn == 0) d_cap = d_rdata;
                dn++; d_mark = k;
            end
            if (i_vld) begin
                if (in_n < 2) iv[in_n] = k;
                if (in_n == 0) i_cap = i_data;
                in_n++; i_mark = k;
            end
        end
        i_en = 1'b0; d_rd = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rr_d0", 256'(dv[0]), 256'd12);
        check("rr_i0", 256'(iv[0]), 256'd27);
        check("rr_d1", 256'(dv[1]), 256'd42);
        check("rr_i1", 256'(iv[1]), 256'd57);
        check("rr_ddata", d_cap, line_b);
        check("rr_idata", i_cap, line_a);

        // Line just past the end of the array
        run_txn(0, 1, 32'h0001_0000, '0, lat, rd);
        check("oor_rd_lat", 256'(lat), 256'd12);
        check("oor_rd_data", rd, '0);
        run_txn(0, 2, 32'h0, line_d, lat, rd);
        run_txn(0, 2, 32'h0001_0000, line_c, lat, rd);
        check("oor_wr_lat", 256'(lat), 256'd12);
        run_txn(0, 1, 32'h0, '0, lat, rd);
        check("oor_wr_dropped", rd, line_d);

        // Reset during a read burst
        d_rd = 1'b1; d_addr = 32'h100;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("abort_busy", 256'(busy), 256'd0);
        check("abort_valids", 256'({i_vld, d_rvld, d_wvld}), 256'd0);
        check("abort_ddata", d_rdata, '0);
        check("abort_idata", i_data, '0);
        d_rd = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        seen = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (i_vld || d_rvld || d_wvld) seen++;
        end
        check("abort_no_vld", 256'(seen), 256'd0);
        run_txn(0, 1, 32'h200, '0, lat, rd);
        check("post_rst_lat", 256'(lat), 256'd12);
        check("post_rst_data", rd, line_b);

        // Zero-latency build
        run_txn(1, 2, 32'h40, line_e, lat, rd);
        check("z_wr_lat", 256'(lat), 256'd8);
        run_txn(1, 1, 32'h40, '0, lat, rd);
        check("z_rd_lat", 256'(lat), 256'd8);
        check("z_rd_data", rd, line_e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
